if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the 16-bit pipelined CPU. It owns the program counter, presents the fetch address to the RAM2 controller and captures the returned instruction word into the IF/ID pipeline register. It also resolves three things for that register:
- the structural conflict that occurs when the MEM stage takes RAM2 for a data access;
- hazard-unit stalls;
- branch redirects from ID.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, bubble encoding written into IF/ID.
- BOOT_CYCLES, 4, number of cycles after reset before the first fetch (RAM2 settle); legal range 1..255.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard-unit stall; hold PC and IF/ID.
- branch_i  in  1  redirect request from ID (taken branch/jump).
- branch_target_i  in  16  redirect address.
- mem_ram2_i  in  1  MEM stage owns RAM2 this cycle; the same signal drives the RAM2 controller's MEM-select input.
- ram2res_i  in  16  instruction word read from RAM2 at addr_if_o; valid at the rising edge ending the cycle.
- addr_if_o  out  16  fetch address to the RAM2 controller.
- inst_o  out  16  IF/ID instruction.
- pc_o  out  16  address of inst_o.
- valid_o  out  1  IF/ID holds a real instruction; 0 means bubble.
- booting_o  out  1  high while in BOOT.

## Operation
- FSM states:
  - BOOT: a down-counter is loaded with BOOT_CYCLES-1 on reset and decrements each cycle. When the counter reads 0, the FSM moves to RUN. No other input affects BOOT; branch_i and stall_i are ignored.
  - RUN: normal fetch.
- addr_if_o is driven directly from the PC register and is never combinational from the inputs.
- Per-edge action in RUN, in strict priority order:
  - branch_i=1: PC <= branch_target_i; IF/ID <= {NOP_INST, pc unchanged, valid 0}. This is a flush, and branch wins even if stall_i or mem_ram2_i is high.
  - stall_i=1: PC and IF/ID hold all fields.
  - mem_ram2_i=1: PC holds; IF/ID <= bubble (NOP_INST, valid 0). The word on ram2res_i is discarded, because the bus carried MEM data.
  - Otherwise: IF/ID <= {ram2res_i, PC, valid 1}; PC <= PC+1.
- PC arithmetic is 16-bit modulo, so 16'hFFFF+1 = 16'h0000 with no flag.
- A bubble never advances the PC, so the instruction that lost the conflict is refetched next cycle.
- Reset values (also held through BOOT):
  - PC = RESET_PC
  - inst_o = NOP_INST
  - pc_o = RESET_PC
  - valid_o = 0
  - booting_o = 1
- rst asserted mid-operation overrides everything at that edge and returns the FSM to BOOT with the counter reloaded.

## Timing
- Fetch latency is 1 cycle. The PC is presented during cycle N, and the instruction appears on inst_o after the rising edge ending cycle N.
- Branch penalty, when branch_i is high in cycle N:
  - cycle N+1: addr_if_o = target, and IF/ID holds a bubble.
  - After the edge ending N+1: inst_o = target instruction.
- Conflict cost is one bubble per cycle that mem_ram2_i is high. Back-to-back conflicts produce back-to-back bubbles with the PC frozen.
- BOOT lasts exactly BOOT_CYCLES cycles after rst deasserts:
  - The first RUN cycle presents RESET_PC.
  - The first valid_o=1 appears BOOT_CYCLES+1 edges after reset release.
- A stall_i that deasserts resumes with the held IF/ID contents unchanged. There is no duplicate capture and no lost instruction.

## Test plan
- Reset/boot: assert rst 2 cycles, then release with BOOT_CYCLES=4 and RAM model word[i]=16'h1000+i.
  - booting_o must be 1 for 4 cycles.
  - Then inst_o=16'h1000, pc_o=0, valid_o=1.
  - Then 16'h1001 and pc_o=1 on consecutive cycles.
- Sequential wrap: force the PC to 16'hFFFE via branch.
  - Fetches at FFFE, FFFF, 0000 must appear in order, with no gap.
- Structural conflict: mem_ram2_i high for 2 cycles while the PC is 5.
  - Two bubbles (inst_o=16'h0800, valid_o=0) must appear.
  - addr_if_o must stay 5.
  - Then inst_o=word[5] with pc_o=5.
- Stall vs conflict: assert stall_i and mem_ram2_i together for 3 cycles.
  - IF/ID must hold its previous valid instruction unchanged, and the PC must be unchanged.
  - After release, the sequence continues without duplicates.
- Branch priority: branch_i=1 with target 16'h0040, together with stall_i=1 and mem_ram2_i=1.
  - The next cycle must show addr_if_o=0040 and a bubble.
  - The cycle after must show inst_o=word[0x40].
- Mid-run reset: assert rst while the PC is 16'h0123 and valid_o=1.
  - The next edge must give all outputs their reset values and booting_o=1.
  - BOOT must repeat for the full 4 cycles.

Source files
------------

// File: rtl/if_fetch_if.sv
// Purpose: groups the fetch stage's control inputs, RAM2 data path and IF/ID outputs.
// Latency: none, signal bundle only.
// Backpressure: stall_i and mem_ram2_i from the environment hold or bubble the fetch stage.
//   master: the fetch stage (drives addr_if_o and the IF/ID fields).
//   slave:  the surrounding pipeline / RAM2 controller.
interface if_fetch_if;
    logic        stall_i;
    logic        branch_i;
    logic [15:0] branch_target_i;
    logic        mem_ram2_i;
    logic [15:0] ram2res_i;
    logic [15:0] addr_if_o;
    logic [15:0] inst_o;
    logic [15:0] pc_o;
    logic        valid_o;
    logic        booting_o;

    modport master (
        input  stall_i, branch_i, branch_target_i, mem_ram2_i, ram2res_i,
        output addr_if_o, inst_o, pc_o, valid_o, booting_o
    );

    modport slave (
        output stall_i, branch_i, branch_target_i, mem_ram2_i, ram2res_i,
        input  addr_if_o, inst_o, pc_o, valid_o, booting_o
    );
endinterface

// File: rtl/if_fetch.sv
// Purpose: instruction fetch stage; owns the PC, drives the RAM2 fetch address, fills IF/ID.
// Latency: 1 cycle from PC presented to instruction in IF/ID; 1 bubble per branch or RAM2 conflict.
// Backpressure: stall_i holds PC and IF/ID; mem_ram2_i inserts a bubble and holds the PC.
// Ports: clk, rst (sync, active-high); fif carries stall/branch/conflict controls, the
//        RAM2 read word, the fetch address and the IF/ID instruction/pc/valid plus booting flag.
module if_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INST    = 16'h0800,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master fif
);

    localparam logic [7:0] BOOT_LOAD = 8'(BOOT_CYCLES - 1);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  boot_cnt;
    logic [15:0] pc;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        booting;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: BOOT ends on the cycle the settle counter reads zero.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  if (boot_cnt == 8'd0) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Output logic.
    always_comb begin
        booting = 1'b0;
        if (state == S_BOOT) begin
            booting = 1'b1;
        end
    end

    // RAM2 settle counter, only meaningful while in BOOT.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_cnt <= BOOT_LOAD;
        end else if (state == S_BOOT && boot_cnt != 8'd0) begin
            boot_cnt <= boot_cnt - 8'd1;
        end
    end

    // PC and IF/ID register. Priority: branch flush, stall hold, RAM2 conflict bubble, fetch.
    // A bubble leaves the PC alone so the word that lost RAM2 is refetched next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_inst  <= NOP_INST;
            ifid_pc    <= RESET_PC;
            ifid_valid <= 1'b0;
        end else if (state == S_RUN) begin
            if (fif.branch_i) begin
                pc         <= fif.branch_target_i;
                ifid_inst  <= NOP_INST;
                ifid_valid <= 1'b0;
            end else if (fif.stall_i) begin
                pc         <= pc;
            end else if (fif.mem_ram2_i) begin
                ifid_inst  <= NOP_INST;
                ifid_valid <= 1'b0;
            end else begin
                ifid_inst  <= fif.ram2res_i;
                ifid_pc    <= pc;
                ifid_valid <= 1'b1;
                pc         <= pc + 16'd1;
            end
        end
    end

    assign fif.addr_if_o = pc;
    assign fif.inst_o    = ifid_inst;
    assign fif.pc_o      = ifid_pc;
    assign fif.valid_o   = ifid_valid;
    assign fif.booting_o = booting;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam logic [15:0] NOP = 16'h0800;
    localparam int          BOOT = 4;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] inst;
        logic [15:0] pc;
        logic        valid;
        logic        boot;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    // Reference model state: abstract boot countdown plus plain PC / IF/ID values.
    int          m_boot_left;
    logic [15:0] m_pc;
    logic [15:0] m_inst;
    logic [15:0] m_ipc;
    logic        m_valid;

    if_fetch_if fif();

    if_fetch #(
        .RESET_PC    (16'h0000),
        .NOP_INST    (NOP),
        .BOOT_CYCLES (BOOT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    function automatic logic [15:0] word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // RAM2 model: instruction memory, or unrelated MEM data when MEM owns the bus.
    assign fif.ram2res_i = fif.mem_ram2_i ? 16'hDEAD : word(fif.addr_if_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every negedge, compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_addr",    {16'd0, fif.addr_if_o}, {16'd0, e.addr});
            chk("sb_inst",    {16'd0, fif.inst_o},    {16'd0, e.inst});
            chk("sb_pc",      {16'd0, fif.pc_o},      {16'd0, e.pc});
            chk("sb_valid",   {31'd0, fif.valid_o},   {31'd0, e.valid});
            chk("sb_booting", {31'd0, fif.booting_o}, {31'd0, e.boot});
        end
    end

    // Apply one cycle of inputs, advance the reference model, queue its prediction.
    task automatic step(input logic r, input logic st, input logic br,
                        input logic [15:0] tgt, input logic mr);
        exp_t e;
        rst                 = r;
        fif.stall_i         = st;
        fif.branch_i        = br;
        fif.branch_target_i = tgt;
        fif.mem_ram2_i      = mr;
        if (r) begin
            m_boot_left = BOOT;
            m_pc        = 16'h0000;
            m_inst      = NOP;
            m_ipc       = 16'h0000;
            m_valid     = 1'b0;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (br) begin
            m_pc    = tgt;
            m_inst  = NOP;
            m_valid = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (mr) begin
            m_inst  = NOP;
            m_valid = 1'b0;
        end else begin
            m_inst  = word(m_pc);
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
        end
        e.addr  = m_pc;
        e.inst  = m_inst;
        e.pc    = m_ipc;
        e.valid = m_valid;
        e.boot  = (m_boot_left > 0);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        m_boot_left = BOOT;
        m_pc        = 16'h0000;
        m_inst      = NOP;
        m_ipc       = 16'h0000;
        m_valid     = 1'b0;
        rst                 = 1'b1;
        fif.stall_i         = 1'b0;
        fif.branch_i        = 1'b0;
        fif.branch_target_i = 16'h0000;
        fif.mem_ram2_i      = 1'b0;

        // Reset and boot; inputs during BOOT must be ignored.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_inst",    {16'd0, fif.inst_o}, {16'd0, NOP});
        chk("rst_valid",   {31'd0, fif.valid_o}, 32'd0);
        chk("rst_booting", {31'd0, fif.booting_o}, 32'd1);
        for (int i = 0; i < BOOT; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0);
            chk("boot_flag", {31'd0, fif.booting_o}, (i < BOOT - 1) ? 32'd1 : 32'd0);
        end
        chk("boot_addr", {16'd0, fif.addr_if_o}, 32'h0000);
        idle();
        chk("first_inst",  {16'd0, fif.inst_o}, 32'h1000);
        chk("first_pc",    {16'd0, fif.pc_o}, 32'h0000);
        chk("first_valid", {31'd0, fif.valid_o}, 32'd1);
        idle();
        chk("second_inst", {16'd0, fif.inst_o}, 32'h1001);
        chk("second_pc",   {16'd0, fif.pc_o}, 32'h0001);

        // Structural conflict at PC 5.
        idle(); idle(); idle();
        chk("pre_conf_addr", {16'd0, fif.addr_if_o}, 32'h0005);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
            chk("conf_inst",  {16'd0, fif.inst_o}, {16'd0, NOP});
            chk("conf_valid", {31'd0, fif.valid_o}, 32'd0);
            chk("conf_addr",  {16'd0, fif.addr_if_o}, 32'h0005);
        end
        idle();
        chk("post_conf_inst", {16'd0, fif.inst_o}, 32'h1005);
        chk("post_conf_pc",   {16'd0, fif.pc_o}, 32'h0005);

        // Stall together with conflict: stall wins, IF/ID holds.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
            chk("stall_inst",  {16'd0, fif.inst_o}, 32'h1005);
            chk("stall_valid", {31'd0, fif.valid_o}, 32'd1);
            chk("stall_addr",  {16'd0, fif.addr_if_o}, 32'h0006);
        end
        idle();
        chk("post_stall_inst", {16'd0, fif.inst_o}, 32'h1006);
        chk("post_stall_pc",   {16'd0, fif.pc_o}, 32'h0006);

        // Branch beats stall and conflict.
        step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
        chk("br_addr",  {16'd0, fif.addr_if_o}, 32'h0040);
        chk("br_valid", {31'd0, fif.valid_o}, 32'd0);
        chk("br_inst",  {16'd0, fif.inst_o}, {16'd0, NOP});
        idle();
        chk("br_target_inst", {16'd0, fif.inst_o}, 32'h1040);
        chk("br_target_pc",   {16'd0, fif.pc_o}, 32'h0040);

        // PC wrap.
        step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        idle();
        chk("wrap_pc0", {16'd0, fif.pc_o}, 32'hFFFE);
        idle();
        chk("wrap_pc1", {16'd0, fif.pc_o}, 32'hFFFF);
        idle();
        chk("wrap_pc2",   {16'd0, fif.pc_o}, 32'h0000);
        chk("wrap_inst2", {16'd0, fif.inst_o}, 32'h1000);

        // Mid-run reset while PC is 0x0123 with a valid instruction in IF/ID.
        step(1'b0, 1'b0, 1'b1, 16'h0122, 1'b0);
        idle();
        chk("pre_rst_addr",  {16'd0, fif.addr_if_o}, 32'h0123);
        chk("pre_rst_valid", {31'd0, fif.valid_o}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("mrst_addr",    {16'd0, fif.addr_if_o}, 32'h0000);
        chk("mrst_inst",    {16'd0, fif.inst_o}, {16'd0, NOP});
        chk("mrst_pc",      {16'd0, fif.pc_o}, 32'h0000);
        chk("mrst_valid",   {31'd0, fif.valid_o}, 32'd0);
        chk("mrst_booting", {31'd0, fif.booting_o}, 32'd1);
        for (int i = 0; i < BOOT; i++) begin
            idle();
            chk("reboot_flag", {31'd0, fif.booting_o}, (i < BOOT - 1) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic r, st, br, mr;
            logic [15:0] tgt;
            r   = ($urandom_range(0, 149) == 0);
            br  = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 4) == 0);
            mr  = ($urandom_range(0, 4) == 0);
            tgt = 16'($urandom);
            step(r, st, br, tgt, mr);
        end

        idle();
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
